// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core -- multiply/divide unit for the execute stage.
//
// Accepts one mult/multu/div/divu (and, with MDU_MADD_EN, madd/maddu/msub/
// msubu) per issue. The result is computed at issue and held as a pending
// HI'/LO' pair. A countdown then models the fixed latency, and the pending
// pair is committed to HI/LO on the edge where the count reaches zero.
// mthi/mtlo write in a single cycle. mfhi/mflo read HI/LO combinationally.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> select codes 9..12 (madd, maddu, msub, msubu) accumulate
//                into {HI,LO} with MULT_CYCLES latency.
//   undefined -> codes 9..12 behave as "none".
//
// Parameters:
//   MULT_CYCLES  busy cycles for the multiply family (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1, >= MULT_CYCLES)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req        in   exception/interrupt in execute; blocks any issue this cycle
//   A, B       in   32-bit forwarded operands rs / rt
//   E_sel_MDU  in   4-bit operation select
//   E_mdu      out  HI for mfhi, LO for mflo, else 0 (combinational)
//   busy       out  registered; high while a multi-cycle op is in flight
//   start      out  combinational; high in the cycle a multi-cycle op issues
// -----------------------------------------------------------------------------
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  E_sel_MDU,
  output logic [31:0] E_mdu,
  output logic        busy,
  output logic        start
);

  localparam logic [3:0] SEL_MULT  = 4'd1;
  localparam logic [3:0] SEL_MULTU = 4'd2;
  localparam logic [3:0] SEL_DIV   = 4'd3;
  localparam logic [3:0] SEL_DIVU  = 4'd4;
  localparam logic [3:0] SEL_MFHI  = 4'd5;
  localparam logic [3:0] SEL_MFLO  = 4'd6;
  localparam logic [3:0] SEL_MTHI  = 4'd7;
  localparam logic [3:0] SEL_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] SEL_MADD  = 4'd9;
  localparam logic [3:0] SEL_MADDU = 4'd10;
  localparam logic [3:0] SEL_MSUB  = 4'd11;
  localparam logic [3:0] SEL_MSUBU = 4'd12;
`endif

  // The counter only ever holds N-1, so DIV_CYCLES-1 is the largest value.
  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic             is_mul, is_div;
  logic [63:0]      a_sx, b_sx, prod_s, prod_u;
  logic             div_signed, a_neg, b_neg;
  logic [31:0]      a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [31:0]      nxt_hi, nxt_lo;
  logic             nxt_wr;

  // ---------------------------------------------------------------------------
  // Decode of multi-cycle operations
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (E_sel_MDU)
      SEL_MULT, SEL_MULTU: is_mul = 1'b1;
      SEL_DIV,  SEL_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      SEL_MADD, SEL_MADDU, SEL_MSUB, SEL_MSUBU: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  // busy is only ever high in RUN, so !busy is the IDLE qualifier.
  assign start = (is_mul | is_div) & ~busy & ~req;

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated on the operands presented at issue
  // ---------------------------------------------------------------------------
  // The low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product, so one unsigned multiplier form serves both.
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes and the signs are restored afterwards.
  // This truncates toward zero, gives the remainder the dividend's sign, and
  // yields 0x80000000 / 0xFFFFFFFF = 0x80000000 rem 0 without a special case.
  assign div_signed = (E_sel_MDU == SEL_DIV);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  assign a_mag      = a_neg ? -A : A;
  assign b_mag      = b_neg ? -B : B;
  // A zero divisor is never committed; forcing 0 keeps the value defined.
  assign q_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  // Pending result captured at issue; nxt_wr=0 leaves HI/LO untouched at commit.
  always_comb begin
    nxt_hi = hi;
    nxt_lo = lo;
    nxt_wr = 1'b1;
    case (E_sel_MDU)
      SEL_MULT:  {nxt_hi, nxt_lo} = prod_s;
      SEL_MULTU: {nxt_hi, nxt_lo} = prod_u;
      SEL_DIV, SEL_DIVU: begin
        if (B == 32'd0) begin
          nxt_wr = 1'b0;
        end else begin
          nxt_hi = rem;
          nxt_lo = quo;
        end
      end
`ifdef MDU_MADD_EN
      SEL_MADD:  {nxt_hi, nxt_lo} = {hi, lo} + prod_s;
      SEL_MADDU: {nxt_hi, nxt_lo} = {hi, lo} + prod_u;
      SEL_MSUB:  {nxt_hi, nxt_lo} = {hi, lo} - prod_s;
      SEL_MSUBU: {nxt_hi, nxt_lo} = {hi, lo} - prod_u;
`endif
      default:   nxt_wr = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // HI/LO read port
  // ---------------------------------------------------------------------------
  always_comb begin
    E_mdu = 32'd0;
    case (E_sel_MDU)
      SEL_MFHI: E_mdu = hi;
      SEL_MFLO: E_mdu = lo;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, countdown and HI/LO state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= nxt_hi;
            pend_lo <= nxt_lo;
            pend_wr <= nxt_wr;
            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            state   <= RUN;
            busy    <= 1'b1;
          end else if (!req) begin
            if (E_sel_MDU == SEL_MTHI) hi <= A;
            if (E_sel_MDU == SEL_MTLO) lo <= A;
          end
        end
        RUN: begin
          // req is deliberately ignored here: an in-flight op always commits.
          if (cnt == '0) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_core.sv
// -----------------------------------------------------------------------------
// tb_mdu_core -- self-checking bench for mdu_core (default parameters).
//
// A behavioural model (plain 64-bit arithmetic plus an absolute "commit cycle")
// runs on every rising edge; one checker on the falling edge compares start,
// busy and E_mdu against it. Directed sequences pin the model with literal
// expectations, then a randomized phase exercises all select codes, req and
// occasional resets. The madd-family section follows MDU_MADD_EN.
// -----------------------------------------------------------------------------
module tb_mdu_core;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] S_NONE  = 4'd0;
  localparam logic [3:0] S_MULT  = 4'd1;
  localparam logic [3:0] S_MULTU = 4'd2;
  localparam logic [3:0] S_DIV   = 4'd3;
  localparam logic [3:0] S_DIVU  = 4'd4;
  localparam logic [3:0] S_MFHI  = 4'd5;
  localparam logic [3:0] S_MFLO  = 4'd6;
  localparam logic [3:0] S_MTHI  = 4'd7;
  localparam logic [3:0] S_MTLO  = 4'd8;
  localparam logic [3:0] S_MADD  = 4'd9;
  localparam logic [3:0] S_MADDU = 4'd10;
  localparam logic [3:0] S_MSUB  = 4'd11;
  localparam logic [3:0] S_MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  E_sel_MDU = S_NONE;
  logic [31:0] E_mdu;
  logic        busy;
  logic        start;

  mdu_core #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .A         (A),
    .B         (B),
    .E_sel_MDU (E_sel_MDU),
    .E_mdu     (E_mdu),
    .busy      (busy),
    .start     (start)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic bit model_multi(input logic [3:0] sel);
    if (sel >= S_MULT && sel <= S_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
    if (sel >= S_MADD && sel <= S_MSUBU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Returns {write_enable, new_hi, new_lo} for an op issued with these inputs.
  function automatic logic [64:0] model_result(input logic [3:0] sel,
                                               input logic [31:0] a, b, hi, lo);
    int          sa, sb;
    longint      sp;
    logic [63:0] up, acc;
    sa  = a;
    sb  = b;
    sp  = longint'(sa) * longint'(sb);
    up  = {32'd0, a} * {32'd0, b};
    acc = {hi, lo};
    case (sel)
      S_MULT:  return {1'b1, sp};
      S_MULTU: return {1'b1, up};
      S_DIV: begin
        if (b == 32'd0) return {1'b0, acc};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0, 32'h8000_0000};
        return {1'b1, 32'(sa % sb), 32'(sa / sb)};
      end
      S_DIVU: begin
        if (b == 32'd0) return {1'b0, acc};
        return {1'b1, a % b, a / b};
      end
      S_MADD:  return {1'b1, acc + sp};
      S_MADDU: return {1'b1, acc + up};
      S_MSUB:  return {1'b1, acc - sp};
      S_MSUBU: return {1'b1, acc - up};
      default: return {1'b0, acc};
    endcase
  endfunction

  bit          m_valid = 1'b0;
  bit          m_inflight = 1'b0;
  int          cyc = 0;
  int          m_done = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid    = 1'b1;
      m_inflight = 1'b0;
      m_hi       = 32'd0;
      m_lo       = 32'd0;
    end else if (m_inflight) begin
      if (cyc == m_done) begin
        if (m_pend[64]) {m_hi, m_lo} = m_pend[63:0];
        m_inflight = 1'b0;
      end
    end else if (!req) begin
      if (model_multi(E_sel_MDU)) begin
        m_pend     = model_result(E_sel_MDU, A, B, m_hi, m_lo);
        m_done     = cyc + ((E_sel_MDU == S_DIV || E_sel_MDU == S_DIVU) ? DIV_N : MULT_N);
        m_inflight = 1'b1;
      end else if (E_sel_MDU == S_MTHI) begin
        m_hi = A;
      end else if (E_sel_MDU == S_MTLO) begin
        m_lo = A;
      end
    end
    cyc++;
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_inflight});
      check("cyc_start", {31'd0, start},
            {31'd0, model_multi(E_sel_MDU) && !m_inflight && !req});
      if (!m_inflight)
        check("cyc_e_mdu", E_mdu,
              (E_sel_MDU == S_MFHI) ? m_hi : (E_sel_MDU == S_MFLO) ? m_lo : 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic [3:0] sel, input logic [31:0] a, b);
    req = r; E_sel_MDU = sel; A = a; B = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op, then count busy cycles (bounded).
  task automatic issue_wait(input logic [3:0] sel, input logic [31:0] a, b, output int nbusy);
    drive(1'b0, sel, a, b);
    tick();
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      tick();
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, l);
    drive(1'b0, S_MFHI, 32'd0, 32'd0); #1 h = E_mdu;
    drive(1'b0, S_MFLO, 32'd0, 32'd0); #1 l = E_mdu;
    drive(1'b0, S_NONE, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          nb;
    logic [31:0] h, l, h0, l0;

    drive(1'b0, S_NONE, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    read_hilo(h, l);
    check("rst_hi", h, 32'd0);
    check("rst_lo", l, 32'd0);

    // mult -3 * 5
    drive(1'b0, S_MULT, 32'hFFFF_FFFD, 32'd5);
    #1 check("mult_start", {31'd0, start}, 32'd1);
    tick();
    check("mult_start_drop", {31'd0, start}, 32'd0);
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    nb = 0;
    while (busy && nb < 100) begin nb++; tick(); end
    check("mult_busy_len", 32'(nb), 32'd5);
    read_hilo(h, l);
    check("mult_hi", h, 32'hFFFF_FFFF);
    check("mult_lo", l, 32'hFFFF_FFF1);

    // divu 7 / 2
    issue_wait(S_DIVU, 32'd7, 32'd2, nb);
    check("divu_busy_len", 32'(nb), 32'd10);
    read_hilo(h, l);
    check("divu_hi", h, 32'd1);
    check("divu_lo", l, 32'd3);

    // div -7 / 2
    issue_wait(S_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    read_hilo(h, l);
    check("div_hi", h, 32'hFFFF_FFFF);
    check("div_lo", l, 32'hFFFF_FFFD);

    // div overflow corner
    issue_wait(S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    read_hilo(h, l);
    check("divovf_hi", h, 32'd0);
    check("divovf_lo", l, 32'h8000_0000);

    // divide by zero: full duration, HI/LO unchanged
    issue_wait(S_DIV, 32'd123, 32'd0, nb);
    check("div0_busy_len", 32'(nb), 32'd10);
    read_hilo(h, l);
    check("div0_hi", h, 32'd0);
    check("div0_lo", l, 32'h8000_0000);

    // mthi with req, then without
    drive(1'b1, S_MTHI, 32'h1234, 32'd0);
    #1 check("mthi_req_start", {31'd0, start}, 32'd0);
    tick();
    read_hilo(h, l);
    check("mthi_req_hi", h, 32'd0);
    drive(1'b0, S_MTHI, 32'h1234, 32'd0);
    tick();
    read_hilo(h, l);
    check("mthi_hi", h, 32'h1234);

    // mtlo and req during busy are ignored; the op still commits
    drive(1'b0, S_MULT, 32'd2, 32'd3);
    tick();
    drive(1'b0, S_MTLO, 32'hAA, 32'd0);
    tick();
    drive(1'b1, S_MULT, 32'd9, 32'd9);
    tick();
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    nb = 0;
    while (busy && nb < 100) begin nb++; tick(); end
    check("busy_ign_len", 32'(nb + 2), 32'd5);
    read_hilo(h, l);
    check("busy_ign_hi", h, 32'd0);
    check("busy_ign_lo", l, 32'd6);

    // reset in the 3rd busy cycle of a div
    drive(1'b0, S_MTHI, 32'h55, 32'd0);
    tick();
    drive(1'b0, S_DIV, 32'd100, 32'd7);
    tick();
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("midrst_hi", h, 32'd0);
    check("midrst_lo", l, 32'd0);
    repeat (15) tick();
    read_hilo(h, l);
    check("midrst_late_hi", h, 32'd0);
    check("midrst_late_lo", l, 32'd0);

`ifdef MDU_MADD_EN
    drive(1'b0, S_MTHI, 32'd0, 32'd0);
    tick();
    drive(1'b0, S_MTLO, 32'hFFFF_FFFF, 32'd0);
    tick();
    issue_wait(S_MADDU, 32'd1, 32'd1, nb);
    check("maddu_busy_len", 32'(nb), 32'd5);
    read_hilo(h, l);
    check("maddu_hi", h, 32'd1);
    check("maddu_lo", l, 32'd0);
`else
    drive(1'b0, S_MTLO, 32'h77, 32'd0);
    tick();
    read_hilo(h0, l0);
    drive(1'b0, S_MADDU, 32'd1, 32'd1);
    #1 check("maddu_off_start", {31'd0, start}, 32'd0);
    tick();
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    check("maddu_off_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("maddu_off_hi", h, h0);
    check("maddu_off_lo", l, l0);
`endif

    // Randomized phase, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), pick32(), pick32());
      tick();
    end
    reset = 1'b0;
    drive(1'b0, S_NONE, 32'd0, 32'd0);
    repeat (DIV_N + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
